// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared definitions for the instruction-fetch front end:
//               fetch FSM state encoding, instruction width and the default
//               reset PC, plus a word-alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'd0,
        FETCH_REQ     = 2'd1,
        FETCH_CAPTURE = 2'd2,
        FETCH_HOLD    = 2'd3
    } fetch_state_t;

    // Instruction addresses are always word aligned; clear the byte offset.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/next_pc_calc.sv
`default_nettype none
// ============================================================================
// Module      : next_pc_calc
// Description : Combinational next-PC selection. A jump overrides a taken
//               branch; with neither, execution falls through to pc + 4.
//               The result is always word aligned.
// Ports       : pc_plus4      in  32  address of the sequential successor
//               jump          in  1   unconditional jump request
//               jump_address  in  26  J-type target field
//               branch_taken  in  1   taken-branch request
//               branch_offset in  32  sign-extended branch immediate (words)
//               next_pc       out 32  selected next instruction address
// Revision    : 1.0 - initial release
// ============================================================================
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic        jump,
    input  logic [25:0] jump_address,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    output logic [31:0] next_pc
);

    logic [31:0] target;

    always_comb begin
        target = pc_plus4;
        if (jump) begin
            // Jump stays inside the current 256 MB region of pc + 4.
            target = {pc_plus4[31:28], jump_address, 2'b00};
        end else if (branch_taken) begin
            // Offset is in words; the shift drops its top two bits, which
            // gives the intended 32-bit modulo result.
            target = pc_plus4 + (branch_offset << 2);
        end
    end

    assign next_pc = word_align(target);

endmodule : next_pc_calc
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch unit driving an external synchronous BRAM.
//               Each instruction walks IDLE/REQ -> CAPTURE -> HOLD: one read
//               strobe, one cycle to latch the BRAM data, then the
//               instruction is presented to the decoder until downstream
//               signals completion, at which point the PC advances.
// Ports       : clk           in  1       clock, rising edge
//               rst           in  1       synchronous active-high reset
//               fetch_en      in  1       run enable
//               imem_ren      out 1       BRAM read strobe
//               imem_addr     out ADDR_W  BRAM word address
//               imem_rdata    in  32      BRAM data, one cycle after strobe
//               instr_reg     out 32      latched instruction
//               decoder_en    out 1       instr_reg holds a valid instruction
//               pc            out 32      address of instruction in instr_reg
//               pc_plus4      out 32      pc + 4
//               next_pc_valid in  1       completion strobe (HOLD only)
//               jump          in  1       jump request (HOLD only)
//               jump_address  in  26      J-type target field
//               branch_taken  in  1       taken-branch request (HOLD only)
//               branch_offset in  32      sign-extended branch immediate
//               instr_count   out 32      completed-instruction counter
//               busy          out 1       FSM not in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
    import mips_pkg::*;
#(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_en,
    output logic               imem_ren,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_reg,
    output logic               decoder_en,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    input  logic               next_pc_valid,
    input  logic               jump,
    input  logic [25:0]        jump_address,
    input  logic               branch_taken,
    input  logic [31:0]        branch_offset,
    output logic [31:0]        instr_count,
    output logic               busy
);

    fetch_state_t state;
    fetch_state_t state_nxt;

    logic [31:0] next_pc;
    logic        complete;

    // Completion is only honoured while an instruction is held; strobes in
    // any other state are dropped.
    assign complete = (state == FETCH_HOLD) && next_pc_valid;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            FETCH_IDLE: begin
                if (fetch_en) begin
                    state_nxt = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                state_nxt = FETCH_CAPTURE;
            end
            FETCH_CAPTURE: begin
                state_nxt = FETCH_HOLD;
            end
            FETCH_HOLD: begin
                // fetch_en is only consulted here, so dropping it earlier
                // lets the in-flight instruction finish normally.
                if (next_pc_valid) begin
                    state_nxt = fetch_en ? FETCH_REQ : FETCH_IDLE;
                end
            end
            default: begin
                state_nxt = FETCH_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-PC selection
    // ------------------------------------------------------------------
    next_pc_calc u_next_pc_calc (
        .pc_plus4      (pc_plus4),
        .jump          (jump),
        .jump_address  (jump_address),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .next_pc       (next_pc)
    );

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= word_align(RESET_PC);
            instr_reg   <= '0;
            instr_count <= '0;
        end else begin
            // A read issued in REQ just before a reset never reaches here:
            // reset forces IDLE, so CAPTURE is never entered for it.
            if (state == FETCH_CAPTURE) begin
                instr_reg <= imem_rdata;
            end
            if (complete) begin
                pc          <= next_pc;
                instr_count <= instr_count + 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all decoded from registered state, so glitch-free)
    // ------------------------------------------------------------------
    assign pc_plus4   = pc + 32'd4;
    assign imem_addr  = pc[ADDR_W+1:2];
    assign imem_ren   = (state == FETCH_REQ);
    assign decoder_en = (state == FETCH_HOLD);
    assign busy       = (state != FETCH_IDLE);

endmodule : instr_fetch
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch with a behavioural BRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              fetch_en;
    logic              imem_ren;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic [31:0]       instr_reg;
    logic              decoder_en;
    logic [31:0]       pc;
    logic [31:0]       pc_plus4;
    logic              next_pc_valid;
    logic              jump;
    logic [25:0]       jump_address;
    logic              branch_taken;
    logic [31:0]       branch_offset;
    logic [31:0]       instr_count;
    logic              busy;

    always #5 clk = ~clk;

    instr_fetch #(.ADDR_W(ADDR_W), .RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_en      (fetch_en),
        .imem_ren      (imem_ren),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .instr_reg     (instr_reg),
        .decoder_en    (decoder_en),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .next_pc_valid (next_pc_valid),
        .jump          (jump),
        .jump_address  (jump_address),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .instr_count   (instr_count),
        .busy          (busy)
    );

    // Synchronous-read BRAM model
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (imem_ren) imem_rdata <= mem[imem_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        jmp;
        logic [25:0] ja;
        logic        br;
        logic [31:0] bo;
        int          hold_cyc;   // extra HOLD cycles before completion
        logic        noise;      // strobes asserted outside HOLD
        logic        stop;       // drop fetch_en during CAPTURE
        logic [31:0] exp_next;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[11];

    task automatic run_vec(input vec_t v, input logic [31:0] cur_pc, input logic [31:0] cur_cnt);
        exp_t e;
        int   req_seen = -1;
        int   cyc = 0;
        bit   got = 0;
        logic [31:0] held_instr;
        e.pc    = cur_pc;
        e.instr = mem[cur_pc[ADDR_W+1:2]];
        sb.push_back(e);
        while (cyc < 16 && !got) begin
            if (decoder_en) begin
                got = 1;
            end else begin
                if (imem_ren) begin
                    chk("imem_addr", {22'b0, imem_addr}, {22'b0, cur_pc[ADDR_W+1:2]});
                    req_seen = cyc;
                end else if (busy && v.stop) begin
                    fetch_en = 1'b0;
                end
                next_pc_valid = v.noise;
                jump          = v.noise;
                branch_taken  = v.noise;
                jump_address  = 26'h3ABCDEF;
                branch_offset = 32'h0000_0100;
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (!got) begin
            chk("hold_timeout", 32'd0, 32'd1);
            return;
        end
        chk("dec_latency", cyc - req_seen, 32'd2);
        e = sb.pop_front();
        chk("instr_reg", instr_reg, e.instr);
        chk("pc", pc, e.pc);
        chk("pc_plus4", pc_plus4, e.pc + 32'd4);
        chk("count_pre", instr_count, cur_cnt);
        held_instr = instr_reg;
        for (int h = 0; h < v.hold_cyc; h++) begin
            next_pc_valid = 1'b0;
            jump          = 1'b1;
            branch_taken  = 1'b1;
            @(posedge clk); #1;
            chk("hold_pc", pc, e.pc);
            chk("hold_instr", instr_reg, held_instr);
            chk("hold_dec", {31'b0, decoder_en}, 32'd1);
        end
        next_pc_valid = 1'b1;
        jump          = v.jmp;
        jump_address  = v.ja;
        branch_taken  = v.br;
        branch_offset = v.bo;
        @(posedge clk); #1;
        next_pc_valid = 1'b0;
        jump          = 1'b0;
        branch_taken  = 1'b0;
        chk("next_pc", pc, v.exp_next);
        chk("count_post", instr_count, cur_cnt + 32'd1);
        chk("dec_off", {31'b0, decoder_en}, 32'd0);
        chk("busy_after", {31'b0, busy}, {31'b0, ~v.stop});
        chk("ren_after", {31'b0, imem_ren}, {31'b0, ~v.stop});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] cur_pc;
        logic [31:0] cnt;
        int          w;

        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'hC0DE_0000 | i;
        mem[0] = 32'h8B88_0000;
        mem[1] = 32'h0000_0020;

        //            jmp  ja          br   bo            hold noise stop exp_next
        vecs[0]  = '{1'b0, 26'h0,       1'b0, 32'h0,        0, 1'b0, 1'b0, 32'h0000_0004};
        vecs[1]  = '{1'b0, 26'h0,       1'b0, 32'h0,        2, 1'b1, 1'b0, 32'h0000_0008};
        vecs[2]  = '{1'b1, 26'h4,       1'b0, 32'h0,        0, 1'b0, 1'b0, 32'h0000_0010};
        vecs[3]  = '{1'b1, 26'h40,      1'b0, 32'h0,        1, 1'b1, 1'b0, 32'h0000_0100};
        vecs[4]  = '{1'b0, 26'h0,       1'b1, 32'hFFFF_FFC7, 0, 1'b0, 1'b0, 32'h0000_0020};
        vecs[5]  = '{1'b0, 26'h0,       1'b1, 32'hFFFF_FFFE, 0, 1'b0, 1'b0, 32'h0000_001C};
        vecs[6]  = '{1'b1, 26'h10,      1'b1, 32'hFFFF_FFFE, 0, 1'b0, 1'b0, 32'h0000_0040};
        vecs[7]  = '{1'b1, 26'h3FFFFFF, 1'b0, 32'h0,        0, 1'b0, 1'b0, 32'h0FFF_FFFC};
        vecs[8]  = '{1'b0, 26'h0,       1'b0, 32'h0,        0, 1'b1, 1'b0, 32'h1000_0000};
        vecs[9]  = '{1'b1, 26'h1,       1'b0, 32'h0,        0, 1'b0, 1'b0, 32'h1000_0004};
        vecs[10] = '{1'b0, 26'h0,       1'b0, 32'h0,        0, 1'b0, 1'b1, 32'h1000_0008};

        rst           = 1'b1;
        fetch_en      = 1'b0;
        next_pc_valid = 1'b0;
        jump          = 1'b0;
        jump_address  = '0;
        branch_taken  = 1'b0;
        branch_offset = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr_reg, 32'h0);
        chk("rst_count", instr_count, 32'h0);
        chk("rst_dec", {31'b0, decoder_en}, 32'd0);
        chk("rst_ren", {31'b0, imem_ren}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);

        rst = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("idle_busy", {31'b0, busy}, 32'd0);
        end

        // Table-driven fetch sequence
        fetch_en = 1'b1;
        cur_pc   = 32'h0;
        cnt      = 32'h0;
        for (int k = 0; k < 11; k++) begin
            run_vec(vecs[k], cur_pc, cnt);
            cur_pc = vecs[k].exp_next;
            cnt    = cnt + 32'd1;
        end
        repeat (2) begin
            @(posedge clk); #1;
            chk("stopped_busy", {31'b0, busy}, 32'd0);
            chk("stopped_pc", pc, cur_pc);
        end
        chk("stopped_count", instr_count, cnt);

        // Reset while holding an instruction
        fetch_en = 1'b1;
        w = 0;
        while (!decoder_en && w < 16) begin
            @(posedge clk); #1;
            w++;
        end
        chk("wait_hold", {31'b0, decoder_en}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midhold_dec", {31'b0, decoder_en}, 32'd0);
        chk("midhold_pc", pc, 32'h0);
        chk("midhold_count", instr_count, 32'h0);
        chk("midhold_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("rst_prio_busy", {31'b0, busy}, 32'd0);

        // Reset in REQ: the pending read must not be latched
        rst = 1'b0;
        @(posedge clk); #1;
        chk("req_ren", {31'b0, imem_ren}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        fetch_en = 1'b0;
        chk("req_rst_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("req_rst_instr", instr_reg, 32'h0);
        chk("req_rst_idle", {31'b0, busy}, 32'd0);

        // Reset in CAPTURE
        fetch_en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("cap_state", {29'b0, busy, imem_ren, decoder_en}, 32'h4);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("cap_rst_instr", instr_reg, 32'h0);
        chk("cap_rst_busy", {31'b0, busy}, 32'd0);
        rst      = 1'b0;
        fetch_en = 1'b0;

        chk("sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_instr_fetch
`default_nettype wire
